// File: rtl/note_scroller.sv
// note_scroller: falling-note engine with lane-wise hit judging, despawn miss counting,
// saturating score counters and combinational per-lane sprite enables.
module note_scroller #(
  parameter int LANES    = 4,
  parameter int SLOTS    = 8,
  parameter int TICK_DIV = 800000,
  parameter int SPEED    = 4,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int NOTE_H   = 16,
  parameter int HIT_Y    = 440,
  parameter int HIT_WIN  = 12,
  parameter int X_W      = 10,
  parameter int Y_W      = 10
) (
  input  logic                       CLOCK_25,
  input  logic                       reset,
  input  logic                       spawn_valid,
  input  logic [LANES-1:0]           spawn_lanes,
  output logic                       spawn_ready,
  input  logic [LANES-1:0]           press,
  input  logic [X_W-1:0]             pixel_x,
  input  logic [Y_W-1:0]             pixel_y,
  output logic [LANES-1:0]           sprite_on,
  output logic                       hit_pulse,
  output logic                       miss_pulse,
  output logic [15:0]                score,
  output logic [15:0]                miss_count,
  output logic [$clog2(SLOTS+1)-1:0] active_count
);
  localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int AW = $clog2(SLOTS + 1);
  localparam int COL_W = SCREEN_W / LANES;
  logic [SLOTS-1:0] valid, valid_n;
  logic [LANES-1:0] mask [SLOTS];
  logic [LANES-1:0] mask_n [SLOTS];
  logic [Y_W-1:0] y [SLOTS];
  logic [Y_W-1:0] y_n [SLOTS];
  logic [CW-1:0] cnt;
  logic [LANES-1:0] prev, rise;
  logic tick, hit_found, free_found;
  logic [16:0] hits, misses, score_sum, miss_sum;

  assign tick = cnt == CW'(TICK_DIV - 1);
  assign rise = press & ~prev;
  assign spawn_ready = ~&valid;
  assign score_sum = {1'b0, score} + hits;
  assign miss_sum = {1'b0, miss_count} + misses;

  // Hits clear bits first, then tick/despawn sees the post-hit masks, then spawn fills a pre-edge free slot.
  always_comb begin
    valid_n = valid;
    mask_n = mask;
    y_n = y;
    hits = '0;
    misses = '0;
    hit_found = 1'b0;
    free_found = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      hit_found = 1'b0;
      for (int s = 0; s < SLOTS; s++)
        if (rise[l] && !hit_found && valid[s] && mask[s][l] &&
            int'(y[s]) + NOTE_H / 2 >= HIT_Y - HIT_WIN &&
            int'(y[s]) + NOTE_H / 2 <= HIT_Y + HIT_WIN) begin
          mask_n[s][l] = 1'b0;
          hit_found = 1'b1;
          hits = hits + 17'd1;
        end
    end
    for (int s = 0; s < SLOTS; s++)
      if (valid[s]) begin
        if (mask_n[s] == '0) valid_n[s] = 1'b0;
        else if (tick) begin
          y_n[s] = y[s] + Y_W'(SPEED);
          if (int'(y[s]) + SPEED >= SCREEN_H) begin
            valid_n[s] = 1'b0;
            for (int b = 0; b < LANES; b++) misses = misses + 17'(mask_n[s][b]);
          end
        end
      end
    for (int s = 0; s < SLOTS; s++)
      if (!valid[s] && !free_found) begin
        free_found = 1'b1;
        if (spawn_valid && spawn_lanes != '0) begin
          valid_n[s] = 1'b1;
          mask_n[s] = spawn_lanes;
          y_n[s] = '0;
        end
      end
  end

  always_comb begin
    sprite_on = '0;
    active_count = '0;
    for (int s = 0; s < SLOTS; s++) begin
      active_count = active_count + AW'(valid[s]);
      for (int l = 0; l < LANES; l++)
        if (valid[s] && mask[s][l] &&
            int'(pixel_x) >= l * COL_W && int'(pixel_x) < (l + 1) * COL_W &&
            int'(pixel_y) >= int'(y[s]) && int'(pixel_y) < int'(y[s]) + NOTE_H)
          sprite_on[l] = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_25) begin
    prev <= press;
    if (reset) begin
      valid <= '0;
      cnt <= '0;
      score <= '0;
      miss_count <= '0;
      hit_pulse <= 1'b0;
      miss_pulse <= 1'b0;
    end else begin
      valid <= valid_n;
      mask <= mask_n;
      y <= y_n;
      cnt <= tick ? '0 : cnt + CW'(1);
      hit_pulse <= hits != '0;
      miss_pulse <= misses != '0;
      score <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
      miss_count <= miss_sum[16] ? 16'hFFFF : miss_sum[15:0];
    end
  end
endmodule

// File: tb/tb_note_scroller.sv
// tb_note_scroller: directed scenarios; pulse events are scoreboarded and checked by a separate monitor.
module tb_note_scroller;
  logic CLOCK_25 = 1'b0;
  logic reset = 1'b1;
  logic spawn_valid = 1'b0;
  logic [3:0] spawn_lanes = '0;
  logic spawn_ready;
  logic [3:0] press = '0;
  logic [9:0] pixel_x = '0;
  logic [9:0] pixel_y = '0;
  logic [3:0] sprite_on;
  logic hit_pulse, miss_pulse;
  logic [15:0] score, miss_count;
  logic [3:0] active_count;

  typedef struct {logic [1:0] k; logic [15:0] s; logic [15:0] m;} ev_t;
  ev_t exp_q[$];
  ev_t mon_e;
  int n_cmp = 0;
  int n_err = 0;

  note_scroller #(.TICK_DIV(4)) dut (
    .CLOCK_25(CLOCK_25), .reset(reset), .spawn_valid(spawn_valid), .spawn_lanes(spawn_lanes),
    .spawn_ready(spawn_ready), .press(press), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .sprite_on(sprite_on), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .score(score),
    .miss_count(miss_count), .active_count(active_count)
  );

  always #50 CLOCK_25 = ~CLOCK_25;

  always @(negedge CLOCK_25)
    if (hit_pulse || miss_pulse) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_pulse: hit=%0b miss=%0b score=%0d misses=%0d, none expected",
                 hit_pulse, miss_pulse, score, miss_count);
      end else begin
        mon_e = exp_q.pop_front();
        if ({hit_pulse, miss_pulse} !== mon_e.k || score !== mon_e.s || miss_count !== mon_e.m) begin
          n_err++;
          $display("FAIL pulse_event: got pulses=%b score=%0d misses=%0d, expected pulses=%b score=%0d misses=%0d",
                   {hit_pulse, miss_pulse}, score, miss_count, mon_e.k, mon_e.s, mon_e.m);
        end
      end
    end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLOCK_25);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input logic [1:0] k, input logic [15:0] s, input logic [15:0] m);
    exp_q.push_back('{k: k, s: s, m: m});
  endtask

  task automatic do_reset(input logic [3:0] p);
    press = p;
    spawn_valid = 1'b0;
    spawn_lanes = '0;
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
  endtask

  typedef struct {logic [9:0] x; logic [9:0] y; logic [3:0] e;} px_t;
  px_t px_tab[10] = '{
    '{10'd320, 10'd100, 4'b0100}, '{10'd479, 10'd115, 4'b0100}, '{10'd400, 10'd108, 4'b0100},
    '{10'd479, 10'd100, 4'b0100}, '{10'd320, 10'd115, 4'b0100}, '{10'd319, 10'd108, 4'b0000},
    '{10'd480, 10'd108, 4'b0000}, '{10'd400, 10'd99,  4'b0000}, '{10'd400, 10'd116, 4'b0000},
    '{10'd480, 10'd116, 4'b0000}
  };

  initial begin
    // Button held through reset must not register as an edge
    press = 4'b0001;
    cyc(1);
    do_reset(4'b0001);
    chk("rst_active", 32'(active_count), 0);
    chk("rst_ready", 32'(spawn_ready), 1);
    chk("rst_score", 32'(score), 0);
    chk("rst_miss", 32'(miss_count), 0);
    chk("rst_pulses", 32'({hit_pulse, miss_pulse}), 0);
    chk("rst_sprite", 32'(sprite_on), 0);
    cyc(3);
    press = 4'b0000;
    cyc(2);
    press = 4'b0001;
    cyc(1);
    chk("offwin_hit", 32'(hit_pulse), 0);
    chk("offwin_score", 32'(score), 0);
    press = 4'b0000;

    // Single lane-1 note hit at y=424
    do_reset(4'b0000);
    spawn_valid = 1'b1;
    spawn_lanes = 4'b0010;
    cyc(1);
    spawn_valid = 1'b0;
    chk("hit_active1", 32'(active_count), 1);
    cyc(423);
    pixel_x = 10'd200;
    pixel_y = 10'd430;
    #1 chk("hit_sprite_pre", 32'(sprite_on), 32'b0010);
    press = 4'b0010;
    expect_ev(2'b10, 16'd1, 16'd0);
    cyc(1);
    chk("hit_score", 32'(score), 1);
    chk("hit_active0", 32'(active_count), 0);
    chk("hit_sprite_post", 32'(sprite_on), 0);
    press = 4'b0000;
    cyc(1);
    chk("hit_pulse_width", 32'(hit_pulse), 0);

    // Two-lane note never pressed falls off the bottom
    do_reset(4'b0000);
    spawn_valid = 1'b1;
    spawn_lanes = 4'b1001;
    cyc(1);
    spawn_valid = 1'b0;
    cyc(478);
    chk("miss_active_pre", 32'(active_count), 1);
    chk("miss_count_pre", 32'(miss_count), 0);
    expect_ev(2'b01, 16'd0, 16'd2);
    cyc(1);
    chk("miss_active_post", 32'(active_count), 0);
    chk("miss_count_post", 32'(miss_count), 2);
    cyc(1);
    chk("miss_pulse_width", 32'(miss_pulse), 0);

    // Fill all slots; a held 9th request waits for the first despawn
    do_reset(4'b0000);
    spawn_valid = 1'b1;
    spawn_lanes = 4'b0001;
    cyc(8);
    spawn_lanes = 4'b0100;
    chk("full_active", 32'(active_count), 8);
    chk("full_ready", 32'(spawn_ready), 0);
    cyc(471);
    chk("full_active_hold", 32'(active_count), 8);
    chk("full_ready_hold", 32'(spawn_ready), 0);
    expect_ev(2'b01, 16'd0, 16'd3);
    cyc(1);
    chk("freed_active", 32'(active_count), 5);
    chk("freed_ready", 32'(spawn_ready), 1);
    chk("freed_miss", 32'(miss_count), 3);
    pixel_x = 10'd400;
    pixel_y = 10'd5;
    cyc(1);
    spawn_valid = 1'b0;
    chk("ninth_active", 32'(active_count), 6);
    chk("ninth_sprite", 32'(sprite_on), 32'b0100);

    // Stacked lane-0 notes: each rise claims only one slot
    do_reset(4'b0000);
    spawn_valid = 1'b1;
    spawn_lanes = 4'b0001;
    cyc(2);
    spawn_valid = 1'b0;
    chk("stack_active2", 32'(active_count), 2);
    cyc(422);
    press = 4'b0001;
    expect_ev(2'b10, 16'd1, 16'd0);
    cyc(1);
    chk("stack_score1", 32'(score), 1);
    chk("stack_active1", 32'(active_count), 1);
    press = 4'b0000;
    cyc(1);
    press = 4'b0001;
    expect_ev(2'b10, 16'd2, 16'd0);
    cyc(1);
    chk("stack_score2", 32'(score), 2);
    chk("stack_active0", 32'(active_count), 0);
    press = 4'b0000;

    // Sprite boundaries for a lane-2 note at y=100
    do_reset(4'b0000);
    spawn_valid = 1'b1;
    spawn_lanes = 4'b0100;
    cyc(1);
    spawn_valid = 1'b0;
    cyc(99);
    foreach (px_tab[i]) begin
      pixel_x = px_tab[i].x;
      pixel_y = px_tab[i].y;
      #1 chk($sformatf("sprite_x%0d_y%0d", px_tab[i].x, px_tab[i].y), 32'(sprite_on), 32'(px_tab[i].e));
    end

    cyc(2);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/note_scroller.md
# note_scroller

Parametrised falling-note engine for the rhythm game: holds up to SLOTS notes in flight, each carrying a lane mask over LANES lanes. All notes advance down the screen on a shared divided tick. The block also judges button presses against a hit window and drives per-lane sprite enables for the VGA pixel pipeline. It sits between the song sequencer, which issues spawn requests, and the renderer/score display.

## Interface
- LANES, 4, number of lanes; screen width split into equal columns
- SLOTS, 8, maximum simultaneous notes
- TICK_DIV, 800000, CLOCK_25 cycles per movement tick
- SPEED, 4, pixels added to y per tick
- SCREEN_W, 640 / SCREEN_H, 480, visible area
- NOTE_H, 16, note height in pixels
- HIT_Y, 440 / HIT_WIN, 12, hit-line row and ± tolerance on note centre
- X_W, 10 / Y_W, 10, pixel coordinate widths; Y_W must hold SCREEN_H+SPEED
- CLOCK_25  in  1  system clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high
- spawn_valid  in  1  sequencer requests a new note
- spawn_lanes  in  LANES  lane mask of requested note
- spawn_ready  out  1  a free slot exists (combinational from registered slot state)
- press  in  LANES  synchronous button levels, one per lane
- pixel_x  in  X_W / pixel_y  in  Y_W  coordinate being rendered
- sprite_on  out  LANES  pixel lies inside a live note in that lane
- hit_pulse  out  1  one-cycle pulse, ≥1 lane hit
- miss_pulse  out  1  one-cycle pulse, ≥1 lane bit despawned unhit
- score  out  16  hits, saturating
- miss_count  out  16  misses, saturating
- active_count  out  $clog2(SLOTS+1)  number of valid slots

## Operation
- Per slot: valid, mask[LANES], y[Y_W]. y is the note's top edge.
- Divider: counter 0..TICK_DIV-1, wraps; tick = (counter == TICK_DIV-1), one cycle.
- Spawn: accepted when spawn_valid && spawn_ready. The lowest-index free slot is set to valid=1, mask=spawn_lanes, y=0. A spawn with spawn_lanes==0 is accepted but allocates no slot.
- Press edge: rise[l] = press[l] && !prev[l]. prev is registered each cycle.
- Hit search per rising lane l: take the lowest-index valid slot with mask[l]=1 and y+NOTE_H/2 within [HIT_Y-HIT_WIN, HIT_Y+HIT_WIN]. Clear that bit. A rise with no match has no effect.
- Lanes are judged independently in the same cycle. score += number of lanes hit.
- Tick: every valid slot gets y += SPEED. If the new y >= SCREEN_H, the slot is freed. miss_count += popcount of its remaining mask bits.
- A slot whose mask becomes 0 through hits is freed immediately.
- Render: sprite_on[l] = OR over valid slots with mask[l] && l*SCREEN_W/LANES <= pixel_x < (l+1)*SCREEN_W/LANES && y <= pixel_y < y+NOTE_H. Purely combinational.
- Saturation: score and miss_count hold at 16'hFFFF.

## Timing
- Reset: all slots invalid, counter=0, score=0, miss_count=0, hit_pulse=0, miss_pulse=0, active_count=0. prev is loaded with press, so a button held through reset produces no edge. After reset, spawn_ready=1.
- A spawn accepted at edge k becomes visible (sprite_on, active_count) after edge k.
- hit_pulse and miss_pulse are registered. Each is high for exactly the cycle after the edge where the event is evaluated.
- Same-cycle ordering, all from pre-edge state:
  - Hit judging uses pre-tick y.
  - Bits hit are cleared before despawn miss counting.
  - A newly spawned slot is not advanced by a coincident tick (y=0).
- A slot freed at edge k is allocatable only from edge k+1, because spawn_ready reflects registered state.
- When full (SLOTS valid), spawn_ready=0 and spawn_valid is ignored. The sequencer must hold the request.
- Reset mid-operation clears everything at that edge, overriding spawn, hit and tick.

## Test plan
- Reset with press=4'b0001 held, then release/re-press off-window: score=0, miss_count=0, no hit_pulse.
- TICK_DIV=4: spawn mask 4'b0010. After 106 ticks (424 cycles), y=424. Rise press[1]: hit_pulse 1 cycle, score=1, slot freed, active_count=0.
- Spawn 4'b1001, never press: on the tick where y reaches 480, slot freed, miss_count=2, miss_pulse 1 cycle.
- Spawn 8 notes on consecutive cycles: spawn_ready=0 after the 8th. A 9th request is held until a despawn; it is accepted the cycle after the free, lowest index.
- Two stacked lane-0 notes, both in window: one rise clears only the lower-index slot; score=1.
- Pixel sweep, note lane 2 at y=100, LANES=4: sprite_on=4'b0100 for x in 320..479, y in 100..115; 0 at x=480 or y=116.
